// File: rtl/blit_pkg.sv
// Shared types and constants for the blit SDRAM arbiter.
package blit_pkg;

  // Default SDRAM word-address width.
  localparam int ADDR_W_DEFAULT = 26;

  // Arbiter phases: idle decision, write streaming, read issue, read return.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_READ_REQ   = 2'd2,
    ST_READ_BURST = 2'd3
  } arb_state_t;

endpackage

// File: rtl/blit_sdram_arbiter_if.sv
// Bundle of the blit read port, blit write port and downstream SDRAM slot.
// The slave modport is the arbiter's view; master is the surrounding system.
interface blit_sdram_arbiter_if
  import blit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);
  // Blit read port
  logic              blitr_sdram_request;
  logic [ADDR_W-1:0] blitr_sdram_address;
  logic              blitr_sdram_ready;
  logic              blitr_sdram_rvalid;
  logic [31:0]       blitr_sdram_rdata;
  logic [ADDR_W-1:0] blitr_sdram_raddress;
  logic              blitr_sdram_complete;

  // Blit write port
  logic              blitw_sdram_request;
  logic [ADDR_W-1:0] blitw_sdram_address;
  logic [3:0]        blitw_sdram_wstrb;
  logic [31:0]       blitw_sdram_wdata;
  logic              blitw_sdram_ready;

  // Downstream SDRAM arbiter slot
  logic              sdram_request;
  logic              sdram_write;
  logic [ADDR_W-1:0] sdram_address;
  logic [3:0]        sdram_wstrb;
  logic [31:0]       sdram_wdata;
  logic              sdram_ready;
  logic              sdram_rvalid;
  logic [31:0]       sdram_rdata;
  logic [ADDR_W-1:0] sdram_raddress;
  logic              sdram_complete;

  modport slave (
    input  blitr_sdram_request, blitr_sdram_address,
    output blitr_sdram_ready, blitr_sdram_rvalid, blitr_sdram_rdata,
           blitr_sdram_raddress, blitr_sdram_complete,
    input  blitw_sdram_request, blitw_sdram_address, blitw_sdram_wstrb, blitw_sdram_wdata,
    output blitw_sdram_ready,
    output sdram_request, sdram_write, sdram_address, sdram_wstrb, sdram_wdata,
    input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete
  );

  modport master (
    output blitr_sdram_request, blitr_sdram_address,
    input  blitr_sdram_ready, blitr_sdram_rvalid, blitr_sdram_rdata,
           blitr_sdram_raddress, blitr_sdram_complete,
    output blitw_sdram_request, blitw_sdram_address, blitw_sdram_wstrb, blitw_sdram_wdata,
    input  blitw_sdram_ready,
    input  sdram_request, sdram_write, sdram_address, sdram_wstrb, sdram_wdata,
    output sdram_ready, sdram_rvalid, sdram_rdata, sdram_raddress, sdram_complete
  );

endinterface

// File: rtl/blit_sdram_arbiter.sv
// Arbitrates the blit read and write ports onto one SDRAM slot.
// Writes stream at one word per cycle; a pending read wins once
// MAX_WRITE_RUN consecutive writes have been accepted. One read burst
// may be outstanding, and its returns are forwarded only while open.
module blit_sdram_arbiter
  import blit_pkg::*;
#(
  parameter int MAX_WRITE_RUN = 8,
  parameter int ADDR_W        = ADDR_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  blit_sdram_arbiter_if.slave bus
);

  localparam int               CNT_W   = $clog2(MAX_WRITE_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WRITE_RUN);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [CNT_W-1:0]  w_run_cnt_next;
  logic [CNT_W-1:0]  w_run_cnt_inc;
  logic              w_run_full;

  logic              w_req;
  logic              w_write;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic              w_rready;
  logic              w_wready;
  logic              w_fwd;

  assign w_run_full    = (r_run_cnt >= CNT_MAX);
  assign w_run_cnt_inc = w_run_full ? CNT_MAX : (r_run_cnt + CNT_W'(1));

  // Next-state and per-state output decode; everything idles to zero.
  always_comb begin
    w_state_next   = r_state;
    w_run_cnt_next = r_run_cnt;
    w_req          = 1'b0;
    w_write        = 1'b0;
    w_xfer         = 1'b0;
    w_addr         = '0;
    w_wstrb        = '0;
    w_wdata        = '0;
    w_rready       = 1'b0;
    w_wready       = 1'b0;
    w_fwd          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Writes win unless the write run has used up its allowance.
        if (bus.blitr_sdram_request && (!bus.blitw_sdram_request || w_run_full)) begin
          w_state_next = ST_READ_REQ;
        end else if (bus.blitw_sdram_request) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_req    = bus.blitw_sdram_request;
        w_write  = 1'b1;
        w_addr   = bus.blitw_sdram_address;
        w_wstrb  = bus.blitw_sdram_wstrb;
        w_wdata  = bus.blitw_sdram_wdata;
        w_wready = bus.sdram_ready;
        w_xfer   = bus.blitw_sdram_request && bus.sdram_ready;
        if (w_xfer) begin
          w_run_cnt_next = w_run_cnt_inc;
        end
        if (!bus.blitw_sdram_request) begin
          w_state_next = ST_IDLE;
        end else if (w_xfer && (w_run_cnt_inc == CNT_MAX) && bus.blitr_sdram_request) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ_REQ: begin
        w_req    = 1'b1;
        w_addr   = bus.blitr_sdram_address;
        w_rready = bus.sdram_ready;
        w_xfer   = bus.sdram_ready;
        if (w_xfer) begin
          w_state_next   = ST_READ_BURST;
          w_run_cnt_next = '0;
        end
      end
      ST_READ_BURST: begin
        w_fwd = 1'b1;
        if (bus.sdram_complete) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and write-run counter registers; reset abandons any open burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_run_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_cnt_next;
    end
  end

  assign bus.sdram_request  = w_req;
  assign bus.sdram_write    = w_write;
  assign bus.sdram_address  = w_addr;
  assign bus.sdram_wstrb    = w_wstrb;
  assign bus.sdram_wdata    = w_wdata;

  assign bus.blitr_sdram_ready = w_rready;
  assign bus.blitw_sdram_ready = w_wready;

  // Read returns only reach the blit port while our burst is open.
  assign bus.blitr_sdram_rvalid   = w_fwd & bus.sdram_rvalid;
  assign bus.blitr_sdram_rdata    = w_fwd ? bus.sdram_rdata : '0;
  assign bus.blitr_sdram_raddress = w_fwd ? bus.sdram_raddress : '0;
  assign bus.blitr_sdram_complete = w_fwd & bus.sdram_complete;

endmodule

// File: tb/tb_blit_sdram_arbiter.sv
// Bench for blit_sdram_arbiter: directed scenarios plus a cycle-level
// behavioural model of the arbitration rules checked every cycle.
module tb_blit_sdram_arbiter;

  localparam int AW   = 26;
  localparam int MAXR = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  blit_sdram_arbiter_if #(.ADDR_W(AW)) bus ();

  blit_sdram_arbiter #(.MAX_WRITE_RUN(MAXR), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Which port currently owns the slot, whether a read is awaiting
  // acceptance, whether a burst is open, and the current write run length.
  bit m_write_owner;
  bit m_read_issue;
  bit m_burst_open;
  int m_run;

  logic              e_req, e_wr, e_rrdy, e_wrdy, e_rv, e_rc;
  logic [AW-1:0]     e_addr, e_ra;
  logic [3:0]        e_ws;
  logic [31:0]       e_wd, e_rd;
  bit                m_acc;

  always @(negedge clock) begin
    if (reset) begin
      m_write_owner = 0;
      m_read_issue  = 0;
      m_burst_open  = 0;
      m_run         = 0;
    end
    e_req = 0; e_wr = 0; e_rrdy = 0; e_wrdy = 0; e_rv = 0; e_rc = 0;
    e_addr = '0; e_ra = '0; e_ws = '0; e_wd = '0; e_rd = '0;
    if (m_write_owner) begin
      e_req  = bus.blitw_sdram_request;
      e_wr   = 1;
      e_addr = bus.blitw_sdram_address;
      e_ws   = bus.blitw_sdram_wstrb;
      e_wd   = bus.blitw_sdram_wdata;
      e_wrdy = bus.sdram_ready;
    end else if (m_read_issue) begin
      e_req  = 1;
      e_addr = bus.blitr_sdram_address;
      e_rrdy = bus.sdram_ready;
    end else if (m_burst_open) begin
      e_rv = bus.sdram_rvalid;
      e_rd = bus.sdram_rdata;
      e_ra = bus.sdram_raddress;
      e_rc = bus.sdram_complete;
    end
    check("sdram_request", 64'(bus.sdram_request), 64'(e_req));
    check("sdram_write",   64'(bus.sdram_write),   64'(e_wr));
    check("sdram_address", 64'(bus.sdram_address), 64'(e_addr));
    check("sdram_wstrb",   64'(bus.sdram_wstrb),   64'(e_ws));
    check("sdram_wdata",   64'(bus.sdram_wdata),   64'(e_wd));
    check("blitr_ready",   64'(bus.blitr_sdram_ready), 64'(e_rrdy));
    check("blitw_ready",   64'(bus.blitw_sdram_ready), 64'(e_wrdy));
    check("blitr_rvalid",  64'(bus.blitr_sdram_rvalid), 64'(e_rv));
    check("blitr_rdata",   64'(bus.blitr_sdram_rdata), 64'(e_rd));
    check("blitr_raddr",   64'(bus.blitr_sdram_raddress), 64'(e_ra));
    check("blitr_complete",64'(bus.blitr_sdram_complete), 64'(e_rc));
    if (!reset) begin
      if (!m_write_owner && !m_read_issue && !m_burst_open) begin
        if (bus.blitr_sdram_request && (!bus.blitw_sdram_request || m_run >= MAXR))
          m_read_issue = 1;
        else if (bus.blitw_sdram_request)
          m_write_owner = 1;
      end else if (m_write_owner) begin
        m_acc = bus.blitw_sdram_request && bus.sdram_ready;
        if (m_acc) m_run = (m_run < MAXR) ? m_run + 1 : MAXR;
        if (!bus.blitw_sdram_request || (m_acc && m_run == MAXR && bus.blitr_sdram_request))
          m_write_owner = 0;
      end else if (m_read_issue) begin
        if (bus.sdram_ready) begin
          m_read_issue = 0;
          m_burst_open = 1;
          m_run        = 0;
        end
      end else begin
        if (bus.sdram_complete) m_burst_open = 0;
      end
    end
  end

  // ---------------- stimulus drivers and statistics ----------------
  int            cyc;
  int            n_wr_acc, first_wr_cyc, last_wr_cyc, wr_before_rd;
  int            rd_acc_cyc, n_rd_words;
  logic [AW-1:0] rd_acc_addr;
  logic [31:0]   last_rdata;

  int            wr_left, wr_idx;
  logic [AW-1:0] wr_base;

  int            rd_n_beats, rd_beats_left, rd_beat_idx;
  bit            rd_driving, rd_done;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data_base;

  task automatic clear_stats();
    cyc = 0; n_wr_acc = 0; first_wr_cyc = -1; last_wr_cyc = -1; wr_before_rd = -1;
    rd_acc_cyc = -1; n_rd_words = 0; rd_acc_addr = '0; last_rdata = '0;
  endtask

  task automatic wr_drive();
    if (wr_left > 0) begin
      bus.blitw_sdram_request = 1'b1;
      bus.blitw_sdram_address = wr_base + AW'(wr_idx);
      bus.blitw_sdram_wdata   = 32'hC0DE_0000 + 32'(wr_idx);
      bus.blitw_sdram_wstrb   = 4'(wr_idx) ^ 4'hF;
    end else begin
      bus.blitw_sdram_request = 1'b0;
      bus.blitw_sdram_address = '0;
      bus.blitw_sdram_wdata   = '0;
      bus.blitw_sdram_wstrb   = '0;
    end
  endtask

  task automatic start_read(input logic [AW-1:0] addr, input int beats, input logic [31:0] dbase);
    rd_addr = addr; rd_n_beats = beats; rd_data_base = dbase; rd_done = 0;
    bus.blitr_sdram_request = 1'b1;
    bus.blitr_sdram_address = addr;
  endtask

  // One clock: sample handshakes mid-cycle, then update drivers after the edge.
  task automatic step();
    bit w_acc, r_acc;
    @(negedge clock);
    w_acc = bus.blitw_sdram_request && bus.blitw_sdram_ready;
    r_acc = bus.blitr_sdram_request && bus.blitr_sdram_ready;
    if (w_acc) begin
      n_wr_acc++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (r_acc) begin
      rd_acc_cyc = cyc; rd_acc_addr = bus.sdram_address; wr_before_rd = n_wr_acc;
      $display("cyc %0d: read accepted addr %0h after %0d writes", cyc, bus.sdram_address, n_wr_acc);
    end
    if (bus.blitr_sdram_rvalid) begin
      n_rd_words++; last_rdata = bus.blitr_sdram_rdata;
    end
    @(posedge clock);
    #1;
    cyc++;
    if (w_acc) begin wr_idx++; wr_left--; end
    wr_drive();
    if (r_acc) begin
      bus.blitr_sdram_request = 1'b0;
      bus.blitr_sdram_address = '0;
      rd_beats_left = rd_n_beats; rd_beat_idx = 0; rd_driving = 1;
    end
    if (rd_driving) begin
      if (rd_beats_left > 0) begin
        bus.sdram_rvalid   = 1'b1;
        bus.sdram_rdata    = rd_data_base + 32'(rd_beat_idx);
        bus.sdram_raddress = rd_addr + AW'(rd_beat_idx);
        bus.sdram_complete = (rd_beats_left == 1);
        rd_beats_left--; rd_beat_idx++;
      end else begin
        bus.sdram_rvalid = 1'b0; bus.sdram_rdata = '0;
        bus.sdram_raddress = '0; bus.sdram_complete = 1'b0;
        rd_driving = 0; rd_done = 1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.blitr_sdram_request = 0; bus.blitr_sdram_address = '0;
    bus.blitw_sdram_request = 0; bus.blitw_sdram_address = '0;
    bus.blitw_sdram_wstrb = '0; bus.blitw_sdram_wdata = '0;
    bus.sdram_ready = 0; bus.sdram_rvalid = 0; bus.sdram_rdata = '0;
    bus.sdram_raddress = '0; bus.sdram_complete = 0;
    wr_left = 0; wr_idx = 0; wr_base = '0; rd_driving = 0; rd_done = 0;
    rd_beats_left = 0; rd_beat_idx = 0; rd_n_beats = 0;
    rd_addr = '0; rd_data_base = '0;
    clear_stats();

    // Reset state: requests present but everything held at zero.
    bus.blitw_sdram_request = 1; bus.blitr_sdram_request = 1; bus.sdram_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_sdram_request", 64'(bus.sdram_request), 64'd0);
    check("reset_blitw_ready",   64'(bus.blitw_sdram_ready), 64'd0);
    bus.blitw_sdram_request = 0; bus.blitr_sdram_request = 0; bus.sdram_ready = 0;
    reset = 0;
    step();

    // Write only: 20 back-to-back words.
    clear_stats(); bus.sdram_ready = 1; wr_left = 20; wr_idx = 0; wr_base = 26'h0100000; wr_drive();
    for (int i = 0; i < 40 && wr_left > 0; i++) step();
    $display("write-only: %0d accepted, first cyc %0d, last cyc %0d", n_wr_acc, first_wr_cyc, last_wr_cyc);
    check("s1_writes", 64'(n_wr_acc), 64'd20);
    check("s1_first_cyc", 64'(first_wr_cyc), 64'd1);
    check("s1_last_cyc",  64'(last_wr_cyc), 64'd20);
    repeat (2) step();

    // Read only: ready arrives at cycle 3, eight returns.
    clear_stats(); bus.sdram_ready = 0; start_read(26'h0000100, 8, 32'hA000_0000);
    for (int i = 0; i < 40 && !rd_done; i++) begin bus.sdram_ready = (cyc >= 3); step(); end
    $display("read-only: accepted cyc %0d, %0d words, last %0h", rd_acc_cyc, n_rd_words, last_rdata);
    check("s2_done", 64'(rd_done), 64'd1);
    check("s2_acc_cyc", 64'(rd_acc_cyc), 64'd3);
    check("s2_acc_addr", 64'(rd_acc_addr), 64'h100);
    check("s2_words", 64'(n_rd_words), 64'd8);
    check("s2_last_rdata", 64'(last_rdata), 64'hA000_0007);
    step();

    // Read stalled five cycles in issue: request/address stable, no ready.
    clear_stats(); bus.sdram_ready = 0; start_read(26'h0002ABC, 1, 32'h5555_0000);
    for (int i = 0; i < 40 && !rd_done; i++) begin
      bus.sdram_ready = (cyc >= 6);
      if (cyc >= 1 && cyc <= 5) begin
        #1;
        check("s4_stall_req", 64'(bus.sdram_request), 64'd1);
        check("s4_stall_addr", 64'(bus.sdram_address), 64'h2ABC);
        check("s4_stall_ready", 64'(bus.blitr_sdram_ready), 64'd0);
      end
      step();
    end
    $display("read-stall: accepted cyc %0d, %0d words", rd_acc_cyc, n_rd_words);
    check("s4_acc_cyc", 64'(rd_acc_cyc), 64'd6);
    check("s4_words", 64'(n_rd_words), 64'd1);
    step();

    // Contention: 30 writes with a read raised at the same time.
    clear_stats(); bus.sdram_ready = 1; wr_left = 30; wr_idx = 0; wr_base = 26'h0200000; wr_drive();
    start_read(26'h0003000, 4, 32'hB000_0000);
    for (int i = 0; i < 120 && (wr_left > 0 || !rd_done); i++) step();
    $display("contention: %0d writes before read, read cyc %0d, %0d writes total, last write cyc %0d",
             wr_before_rd, rd_acc_cyc, n_wr_acc, last_wr_cyc);
    check("s3_writes_before_read", 64'(wr_before_rd), 64'd8);
    check("s3_read_cyc", 64'(rd_acc_cyc), 64'd10);
    check("s3_total_writes", 64'(n_wr_acc), 64'd30);
    check("s3_last_write_cyc", 64'(last_wr_cyc), 64'd37);
    check("s3_read_words", 64'(n_rd_words), 64'd4);
    repeat (2) step();

    // Stray returns while idle must not leak to the read port.
    clear_stats();
    bus.sdram_rvalid = 1; bus.sdram_complete = 1; bus.sdram_rdata = 32'hDEAD_BEEF; bus.sdram_raddress = 26'h3FFFFFF;
    #1;
    check("s5_rvalid_now", 64'(bus.blitr_sdram_rvalid), 64'd0);
    check("s5_rdata_now", 64'(bus.blitr_sdram_rdata), 64'd0);
    repeat (3) step();
    $display("stray returns: %0d words forwarded", n_rd_words);
    check("s5_words", 64'(n_rd_words), 64'd0);
    bus.sdram_rvalid = 0; bus.sdram_complete = 0; bus.sdram_rdata = '0; bus.sdram_raddress = '0;
    step();

    // Reset in the middle of a burst, then a fresh read.
    clear_stats(); start_read(26'h0000400, 8, 32'hC000_0000);
    for (int i = 0; i < 20 && n_rd_words < 3; i++) step();
    check("s6_words_before_reset", 64'(n_rd_words), 64'd3);
    #2;
    reset = 1;
    #1;
    check("s6_reset_rvalid", 64'(bus.blitr_sdram_rvalid), 64'd0);
    check("s6_reset_rdata",  64'(bus.blitr_sdram_rdata), 64'd0);
    check("s6_reset_request", 64'(bus.sdram_request), 64'd0);
    rd_driving = 0; rd_beats_left = 0;
    bus.sdram_rvalid = 1; bus.sdram_complete = 1;
    @(posedge clock);
    #1;
    reset = 0;
    clear_stats();
    step();
    check("s6_post_reset_discard", 64'(n_rd_words), 64'd0);
    bus.sdram_rvalid = 0; bus.sdram_complete = 0; bus.sdram_rdata = '0; bus.sdram_raddress = '0;
    clear_stats(); start_read(26'h0000800, 2, 32'hD000_0000);
    for (int i = 0; i < 40 && !rd_done; i++) step();
    $display("post-reset read: accepted cyc %0d, %0d words, last %0h", rd_acc_cyc, n_rd_words, last_rdata);
    check("s6_acc_cyc", 64'(rd_acc_cyc), 64'd1);
    check("s6_words", 64'(n_rd_words), 64'd2);
    check("s6_last_rdata", 64'(last_rdata), 64'hD000_0001);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
